sys_array_feeder: RTL and testbench
===================================

// Module: sys_array_feeder
// PURPOSE
//  Datapath feeder between the systolic controller and the HxW systolic array.
//  Driven by the controller's mode bit: 1 = weight load, 0 = partial-sum/compute.
//  Load mode: shifts H weight rows into the array.
//  Compute mode: streams activation vectors with diagonal skew (lane i delayed i cycles).
//  Drains the skew pipe on every compute->load turnaround.
// PARAMETERS
//  H   32  array height: weight rows per load, activation lanes
//  W   32  array width: weights per row
//  DW   8  element width in bits
// PORTS
//  clk           in   1      clock
//  rst           in   1      asynchronous, active-low reset
//  load_mode     in   1      controller mode bit; 1 = weight load, 0 = compute
//  wt_valid      in   1      weight row valid
//  wt_ready      out  1      weight row accepted when valid&&ready
//  wt_data       in   W*DW   weight row, element j at [j*DW +: DW]
//  act_valid     in   1      activation vector valid
//  act_ready     out  1      activation vector accepted when valid&&ready
//  act_data      in   H*DW   activation vector, lane i at [i*DW +: DW]
//  arr_w_shift   out  1      array shifts arr_w_data into its top row this cycle
//  arr_w_data    out  W*DW   weight row to array
//  arr_act_valid out  H      per-lane skewed valid
//  arr_act_data  out  H*DW   per-lane skewed activation
//  wts_loaded    out  1      full set of H rows present in array
//  load_err      out  1      sticky: load_mode dropped before H rows; cleared on LOAD entry
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; row_cnt=0; drain_cnt=0; skew pipes cleared.
//    All outputs 0.
//  States and transitions:
//   IDLE:    load_mode=1 -> LOAD (clears row_cnt, load_err, wts_loaded).
//   LOAD:    wt_ready = load_mode && (row_cnt<H).
//            Each accepted beat: row_cnt++.
//            Next cycle: arr_w_shift=1, arr_w_data=beat (latency 1).
//            row_cnt==H and load_mode=0 -> COMPUTE, wts_loaded=1.
//            row_cnt==H and load_mode=1 -> stay in LOAD, wt_ready=0.
//            row_cnt<H and load_mode=0 -> IDLE, load_err=1, wts_loaded=0.
//   COMPUTE: act_ready = ~load_mode.
//            Accepted vector at cycle t: lane i appears on arr_act_* at t+1+i.
//            Cycles with no accept inject valid=0 bubbles into every lane.
//            load_mode=1 -> DRAIN; act_ready drops the same cycle (combinational on load_mode).
//   DRAIN:   act_ready=0, bubbles injected, drain_cnt counts H cycles.
//            Then -> LOAD (row_cnt=0, wts_loaded=0, load_err=0).
//            If load_mode=0 again during DRAIN: finish drain, then -> COMPUTE.
//            Weights are untouched and wts_loaded stays 1.
//  Widths: row_cnt and drain_cnt are $clog2(H+1) bits. No saturation beyond H.
//  arr_w_shift is never 1 outside LOAD+1 cycle.
//  arr_act_valid is never 1 for data accepted outside COMPUTE.
//  wt_valid and act_valid are ignored in states where the matching ready is 0.
//    No data is lost or duplicated.
//  Upstream must hold data stable while valid && !ready.
//  Reset mid-operation: immediate clear. Partially loaded array is not trusted (wts_loaded=0).
// STRUCTURE
//  sys_pkg (shared): typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} feed_state_t;
//    default constants SYS_H, SYS_W, SYS_DW, also used by the controller and the array.
//  Sub-module sys_skew_line #(DEPTH, DW): {valid,data} shift register, DEPTH stages.
//    DEPTH=0 is a wire.
//    Instantiated H times by generate, lane i uses DEPTH=i. An extra output register gives +1.
//  Top file holds the FSM, counters, weight output register and handshake logic.
// TESTING (H=4, W=4, DW=8 unless noted)
//  1 Reset: drive rst=0 mid-LOAD after 2 rows.
//    -> all outputs 0 the same cycle. After release, state IDLE and wts_loaded=0.
//  2 Load: load_mode=1, 4 rows 0x01..,0x04.. back-to-back.
//    -> arr_w_shift high 4 cycles, each 1 cycle after accept, data in order.
//    -> wt_ready=0 after the 4th row. Drop load_mode -> wts_loaded=1.
//  3 Abort: load_mode=1, 2 rows, then load_mode=0.
//    -> load_err=1, wts_loaded=0, state IDLE.
//    -> next load_mode=1 clears load_err.
//  4 Skew: COMPUTE, send act lanes {0x10,0x20,0x30,0x40} at cycle t.
//    -> lane i valid with its value exactly at t+1+i, all other cycles valid=0.
//    -> also run with act_valid toggling every other cycle: bubbles are preserved.
//  5 Turnaround: load_mode=1 while 3 vectors are in flight.
//    -> act_ready=0 that cycle, all in-flight lanes emerge, H drain cycles, then wt_ready=1.
//  6 Backpressure: wt_valid held with load_mode=0 in COMPUTE, act_valid held in LOAD.
//    -> no arr_w_shift and no arr_act_valid pulses. Scoreboard shows zero lost or duplicated beats.

Source files
------------

// File: rtl/sys_array_feeder_pkg.sv
// Shared types and default geometry for the systolic feeder, controller and array.
package sys_array_feeder_pkg;

    localparam int SYS_H  = 32;
    localparam int SYS_W  = 32;
    localparam int SYS_DW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } feed_state_t;

endpackage

// File: rtl/sys_array_feeder_if.sv
// Controller/array-facing signal bundle of the feeder.
interface sys_array_feeder_if
    import sys_array_feeder_pkg::*;
#(
    parameter int H  = SYS_H,
    parameter int W  = SYS_W,
    parameter int DW = SYS_DW
);

    logic              load_mode;
    logic              wt_valid;
    logic              wt_ready;
    logic [W*DW-1:0]   wt_data;
    logic              act_valid;
    logic              act_ready;
    logic [H*DW-1:0]   act_data;
    logic              arr_w_shift;
    logic [W*DW-1:0]   arr_w_data;
    logic [H-1:0]      arr_act_valid;
    logic [H*DW-1:0]   arr_act_data;
    logic              wts_loaded;
    logic              load_err;

    // The feeder itself uses the slave view; the controller/array side uses master.
    modport slave (
        input  load_mode, wt_valid, wt_data, act_valid, act_data,
        output wt_ready, act_ready, arr_w_shift, arr_w_data,
               arr_act_valid, arr_act_data, wts_loaded, load_err
    );

    modport master (
        output load_mode, wt_valid, wt_data, act_valid, act_data,
        input  wt_ready, act_ready, arr_w_shift, arr_w_data,
               arr_act_valid, arr_act_data, wts_loaded, load_err
    );

endinterface

// File: rtl/sys_skew_line.sv
// {valid,data} delay line of DEPTH register stages; DEPTH=0 passes straight through.
module sys_skew_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    genvar gi;

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign valid_o        = valid_i;
            assign data_o         = data_i;
        end else begin : g_pipe
            logic          v_q [DEPTH];
            logic [DW-1:0] d_q [DEPTH];

            for (gi = 0; gi < DEPTH; gi++) begin : g_stage
                if (gi == 0) begin : g_head
                    always_ff @(posedge clk or negedge rst) begin
                        if (!rst) begin
                            v_q[0] <= 1'b0;
                            d_q[0] <= '0;
                        end else begin
                            v_q[0] <= valid_i;
                            d_q[0] <= data_i;
                        end
                    end
                end else begin : g_tail
                    always_ff @(posedge clk or negedge rst) begin
                        if (!rst) begin
                            v_q[gi] <= 1'b0;
                            d_q[gi] <= '0;
                        end else begin
                            v_q[gi] <= v_q[gi-1];
                            d_q[gi] <= d_q[gi-1];
                        end
                    end
                end
            end

            assign valid_o = v_q[DEPTH-1];
            assign data_o  = d_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sys_array_feeder.sv
// Feeds weight rows (load mode) and diagonally skewed activations (compute mode)
// into the HxW systolic array, draining the skew pipe on every compute->load turn.
module sys_array_feeder
    import sys_array_feeder_pkg::*;
#(
    parameter int H  = SYS_H,
    parameter int W  = SYS_W,
    parameter int DW = SYS_DW
) (
    input  logic              clk,
    input  logic              rst,
    sys_array_feeder_if.slave bus
);

    localparam int            CW         = $clog2(H + 1);
    localparam logic [CW-1:0] ROWS_FULL  = CW'(H);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(H - 1);

    feed_state_t     state_q, state_d;
    logic [CW-1:0]   row_cnt_q, row_cnt_d;
    logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
    logic            wts_loaded_q, wts_loaded_d;
    logic            load_err_q, load_err_d;
    logic            wt_ready, act_ready, wt_fire, act_fire;
    logic            arr_w_shift_q;
    logic [W*DW-1:0] arr_w_data_q;
    logic [H-1:0]    lane_valid, arr_act_valid_q;
    logic [H*DW-1:0] lane_data, arr_act_data_q, act_in_data;

    // Readies are decoded from registered state so reset forces them low at once.
    assign wt_ready  = (state_q == LOAD) && bus.load_mode && (row_cnt_q < ROWS_FULL);
    assign act_ready = (state_q == COMPUTE) && !bus.load_mode;
    assign wt_fire   = bus.wt_valid && wt_ready;
    assign act_fire  = bus.act_valid && act_ready;

    always_comb begin
        state_d      = state_q;
        row_cnt_d    = row_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        wts_loaded_d = wts_loaded_q;
        load_err_d   = load_err_q;
        case (state_q)
            IDLE: begin
                if (bus.load_mode) begin
                    state_d      = LOAD;
                    row_cnt_d    = '0;
                    load_err_d   = 1'b0;
                    wts_loaded_d = 1'b0;
                end
            end
            LOAD: begin
                if (wt_fire) begin
                    row_cnt_d = row_cnt_q + CW'(1);
                end
                if (!bus.load_mode) begin
                    if (row_cnt_q == ROWS_FULL) begin
                        state_d      = COMPUTE;
                        wts_loaded_d = 1'b1;
                    end else begin
                        state_d      = IDLE;
                        load_err_d   = 1'b1;
                        wts_loaded_d = 1'b0;
                    end
                end
            end
            COMPUTE: begin
                if (bus.load_mode) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                // The controller may change its mind mid-drain; the last drain cycle decides.
                if (drain_cnt_q == DRAIN_LAST) begin
                    drain_cnt_d = '0;
                    if (bus.load_mode) begin
                        state_d      = LOAD;
                        row_cnt_d    = '0;
                        wts_loaded_d = 1'b0;
                        load_err_d   = 1'b0;
                    end else begin
                        state_d = COMPUTE;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            row_cnt_q       <= '0;
            drain_cnt_q     <= '0;
            wts_loaded_q    <= 1'b0;
            load_err_q      <= 1'b0;
            arr_w_shift_q   <= 1'b0;
            arr_w_data_q    <= '0;
            arr_act_valid_q <= '0;
            arr_act_data_q  <= '0;
        end else begin
            state_q         <= state_d;
            row_cnt_q       <= row_cnt_d;
            drain_cnt_q     <= drain_cnt_d;
            wts_loaded_q    <= wts_loaded_d;
            load_err_q      <= load_err_d;
            arr_w_shift_q   <= wt_fire;
            if (wt_fire) begin
                arr_w_data_q <= bus.wt_data;
            end
            arr_act_valid_q <= lane_valid;
            arr_act_data_q  <= lane_data;
        end
    end

    genvar gi;

    // Lane gi sits behind gi skew stages plus the shared output register.
    generate
        for (gi = 0; gi < H; gi++) begin : g_lane
            assign act_in_data[gi*DW +: DW] = act_fire ? bus.act_data[gi*DW +: DW] : '0;

            sys_skew_line #(
                .DEPTH (gi),
                .DW    (DW)
            ) u_skew (
                .clk     (clk),
                .rst     (rst),
                .valid_i (act_fire),
                .data_i  (act_in_data[gi*DW +: DW]),
                .valid_o (lane_valid[gi]),
                .data_o  (lane_data[gi*DW +: DW])
            );
        end
    endgenerate

    assign bus.wt_ready      = wt_ready;
    assign bus.act_ready     = act_ready;
    assign bus.arr_w_shift   = arr_w_shift_q;
    assign bus.arr_w_data    = arr_w_data_q;
    assign bus.arr_act_valid = arr_act_valid_q;
    assign bus.arr_act_data  = arr_act_data_q;
    assign bus.wts_loaded    = wts_loaded_q;
    assign bus.load_err      = load_err_q;

endmodule

// File: tb/tb_sys_array_feeder.sv
// Directed bench for sys_array_feeder with H=W=4, DW=8: vector table plus scoreboarded sequences.
module tb_sys_array_feeder;
    import sys_array_feeder_pkg::*;

    localparam int H  = 4;
    localparam int W  = 4;
    localparam int DW = 8;
    localparam int NC = 512;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sys_array_feeder_if #(.H(H), .W(W), .DW(DW)) bus ();

    sys_array_feeder #(.H(H), .W(W), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected array-side outputs, indexed by cycle number.
    logic            exp_ws [NC];
    logic [W*DW-1:0] exp_wd [NC];
    logic [H-1:0]    exp_av [NC];
    logic [DW-1:0]   exp_ad [NC][H];

    typedef struct {
        logic        lm;
        logic        wv;
        logic [31:0] wd;
        logic        av;
        logic [31:0] ad;
        logic        e_wr;
        logic        e_ar;
        logic        e_wl;
        logic        e_le;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic lm, input logic wv, input logic [31:0] wd,
                                input logic av, input logic [31:0] ad,
                                input logic e_wr, input logic e_ar,
                                input logic e_wl, input logic e_le);
        vec_t v;
        v.lm = lm; v.wv = wv; v.wd = wd; v.av = av; v.ad = ad;
        v.e_wr = e_wr; v.e_ar = e_ar; v.e_wl = e_wl; v.e_le = e_le;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    task automatic clear_exp(input int from);
        for (int k = from; k < NC; k++) begin
            exp_ws[k] = 1'b0;
            exp_wd[k] = '0;
            exp_av[k] = '0;
            for (int i = 0; i < H; i++) exp_ad[k][i] = '0;
        end
    endtask

    task automatic check_zero();
        chk("rst_wt_ready",      32'(bus.wt_ready),      32'd0);
        chk("rst_act_ready",     32'(bus.act_ready),     32'd0);
        chk("rst_arr_w_shift",   32'(bus.arr_w_shift),   32'd0);
        chk("rst_arr_w_data",    32'(bus.arr_w_data),    32'd0);
        chk("rst_arr_act_valid", 32'(bus.arr_act_valid), 32'd0);
        chk("rst_arr_act_data",  32'(bus.arr_act_data),  32'd0);
        chk("rst_wts_loaded",    32'(bus.wts_loaded),    32'd0);
        chk("rst_load_err",      32'(bus.load_err),      32'd0);
    endtask

    // Drive one cycle's inputs, record what must later emerge, check readies at negedge.
    task automatic apply(input logic lm, input logic wv, input logic [W*DW-1:0] wd,
                         input logic av, input logic [H*DW-1:0] ad,
                         input logic e_wr, input logic e_ar);
        bus.load_mode = lm;
        bus.wt_valid  = wv;
        bus.wt_data   = wd;
        bus.act_valid = av;
        bus.act_data  = ad;
        if (wv && e_wr) begin
            exp_ws[cyc+1] = 1'b1;
            exp_wd[cyc+1] = wd;
        end
        if (av && e_ar) begin
            for (int i = 0; i < H; i++) begin
                exp_av[cyc+1+i][i] = 1'b1;
                exp_ad[cyc+1+i][i] = ad[i*DW +: DW];
            end
        end
        @(negedge clk);
        chk("wt_ready",  32'(bus.wt_ready),  32'(e_wr));
        chk("act_ready", 32'(bus.act_ready), 32'(e_ar));
    endtask

    // Compare array-side outputs against the scoreboard, then move to the next cycle.
    task automatic advance();
        chk("arr_w_shift", 32'(bus.arr_w_shift), 32'(exp_ws[cyc]));
        if (exp_ws[cyc]) chk("arr_w_data", 32'(bus.arr_w_data), 32'(exp_wd[cyc]));
        chk("arr_act_valid", 32'(bus.arr_act_valid), 32'(exp_av[cyc]));
        for (int i = 0; i < H; i++) begin
            if (exp_av[cyc][i]) chk("arr_act_data", 32'(bus.arr_act_data[i*DW +: DW]), 32'(exp_ad[cyc][i]));
        end
        $display("cyc=%0d lm=%0b wv=%0b wr=%0b av=%0b ar=%0b wshift=%0b actv=%b wl=%0b le=%0b",
                 cyc, bus.load_mode, bus.wt_valid, bus.wt_ready, bus.act_valid, bus.act_ready,
                 bus.arr_w_shift, bus.arr_act_valid, bus.wts_loaded, bus.load_err);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cyc1(input logic lm, input logic wv, input logic [W*DW-1:0] wd,
                        input logic av, input logic [H*DW-1:0] ad,
                        input logic e_wr, input logic e_ar);
        apply(lm, wv, wd, av, ad, e_wr, e_ar);
        advance();
    endtask

    // Assumes state LOAD: H back-to-back rows, then drop load_mode.
    task automatic load_rows(input logic [7:0] base, input logic av, input logic [31:0] ad);
        logic [7:0] b;
        for (int r = 0; r < H; r++) begin
            b = base + 8'(r);
            cyc1(1'b1, 1'b1, {b, b, b, b}, av, ad, 1'b1, 1'b0);
        end
        cyc1(1'b0, 1'b0, 32'h0, av, ad, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] k8;
        clear_exp(0);
        bus.load_mode = 1'b0;
        bus.wt_valid  = 1'b0;
        bus.wt_data   = '0;
        bus.act_valid = 1'b0;
        bus.act_data  = '0;

        tbl[0]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 32'h01010101, 0, 32'h0,        1, 0, 0, 0);
        tbl[2]  = mk(1, 1, 32'h02020202, 0, 32'h0,        1, 0, 0, 0);
        tbl[3]  = mk(1, 1, 32'h03030303, 0, 32'h0,        1, 0, 0, 0);
        tbl[4]  = mk(1, 1, 32'h04040404, 0, 32'h0,        1, 0, 0, 0);
        tbl[5]  = mk(1, 1, 32'h05050505, 0, 32'h0,        0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0);
        tbl[8]  = mk(0, 0, 32'h0,        1, 32'h44332211, 0, 1, 1, 0);
        tbl[9]  = mk(1, 0, 32'h0,        1, 32'h88776655, 0, 0, 1, 0);
        tbl[10] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 0);
        tbl[11] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 0);
        tbl[12] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 0);
        tbl[13] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 1, 0);
        tbl[14] = mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0);
        tbl[15] = mk(1, 1, 32'hA1A2A3A4, 0, 32'h0,        1, 0, 0, 0);
        tbl[16] = mk(1, 1, 32'hB1B2B3B4, 0, 32'h0,        1, 0, 0, 0);
        tbl[17] = mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0);
        tbl[18] = mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1);
        tbl[19] = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1);
        tbl[20] = mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0);
        tbl[21] = mk(0, 1, 32'hC1C2C3C4, 0, 32'h0,        0, 0, 0, 0);
        tbl[22] = mk(0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 1);

        // Power-on reset
        @(negedge clk);
        check_zero();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Load, turnaround through drain, abort and error clear
        for (int i = 0; i < 23; i++) begin
            apply(tbl[i].lm, tbl[i].wv, tbl[i].wd, tbl[i].av, tbl[i].ad, tbl[i].e_wr, tbl[i].e_ar);
            chk("wts_loaded", 32'(bus.wts_loaded), 32'(tbl[i].e_wl));
            chk("load_err",   32'(bus.load_err),   32'(tbl[i].e_le));
            advance();
        end

        // Skew: single vector, then alternating valid/bubble
        cyc1(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        load_rows(8'h50, 1'b0, 32'h0);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 32'h40302010, 1'b0, 1'b1);
        chk("wts_loaded_compute", 32'(bus.wts_loaded), 32'd1);
        advance();
        repeat (5) cyc1(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            k8 = 8'(k);
            cyc1(1'b0, 1'b0, 32'h0, (k % 2) == 0,
                 {8'hD0 + k8, 8'hC0 + k8, 8'hB0 + k8, 8'hA0 + k8}, 1'b0, 1'b1);
        end
        repeat (5) cyc1(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Turnaround with 3 vectors in flight; act_valid held through drain and load
        for (int k = 0; k < 3; k++) begin
            k8 = 8'(k);
            cyc1(1'b0, 1'b0, 32'h0, 1'b1, {8'hE3 + k8, 8'hE2 + k8, 8'hE1 + k8, 8'hE0 + k8}, 1'b0, 1'b1);
        end
        cyc1(1'b1, 1'b0, 32'h0, 1'b1, 32'hFEEDF00D, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 32'h0, 1'b1, 32'hFEEDF00D, 1'b0, 1'b0);
        chk("state_drain", 32'(dut.state_q), 32'(DRAIN));
        advance();
        repeat (3) cyc1(1'b1, 1'b0, 32'h0, 1'b1, 32'hFEEDF00D, 1'b0, 1'b0);
        cyc1(1'b1, 1'b0, 32'h0, 1'b1, 32'hFEEDF00D, 1'b1, 1'b0);
        load_rows(8'h60, 1'b1, 32'hFEEDF00D);
        cyc1(1'b0, 1'b0, 32'h0, 1'b1, 32'hFEEDF00D, 1'b0, 1'b1);

        // Weight backpressure while computing
        repeat (4) cyc1(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b1);
        repeat (4) cyc1(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Drain interrupted by load_mode falling: back to COMPUTE with weights kept
        cyc1(1'b0, 1'b0, 32'h0, 1'b1, 32'h0A0B0C0D, 1'b0, 1'b1);
        cyc1(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (4) cyc1(1'b0, 1'b0, 32'h0, 1'b1, 32'h01020304, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 32'h0, 1'b1, 32'h01020304, 1'b0, 1'b1);
        chk("state_compute", 32'(dut.state_q), 32'(COMPUTE));
        chk("wts_kept", 32'(bus.wts_loaded), 32'd1);
        advance();
        repeat (4) cyc1(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);

        // Reset in the middle of a load
        cyc1(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (4) cyc1(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc1(1'b1, 1'b1, 32'h71717171, 1'b0, 32'h0, 1'b1, 1'b0);
        cyc1(1'b1, 1'b1, 32'h72727272, 1'b0, 32'h0, 1'b1, 1'b0);
        bus.load_mode = 1'b1;
        bus.wt_valid  = 1'b1;
        bus.wt_data   = 32'h73737373;
        rst = 1'b0;
        clear_exp(cyc);
        @(negedge clk);
        check_zero();
        advance();
        cyc1(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        apply(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("state_idle_after_rst", 32'(dut.state_q), 32'(IDLE));
        chk("wts_loaded_after_rst", 32'(bus.wts_loaded), 32'd0);
        advance();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
